// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl
//   Registered controller between the SLC-3 CPU memory interface (MAR/MDR side)
//   and an external asynchronous 16-bit SRAM. It turns a single-cycle request
//   into sequenced CE/OE/WE/UB/LB strobes, a stable ADDR and a tristate Data bus.
//   When an access finishes it returns a one-cycle ready pulse. For a read,
//   rdata carries the data with that pulse.
//
//   Ports:
//     Clk, Reset         clock; asynchronous active-low reset
//     req, we_req        request strobe and write select (sampled in IDLE only)
//     addr, wdata        access address and write data (latched on accept)
//     be[1:0]            byte lanes {upper, lower}; present only with
//                        SRAM_BYTE_LANES_EN defined
//     rdata, ready, busy read data, completion pulse, access in progress
//     CE, OE, WE, UB, LB active-low SRAM strobes
//     ADDR, Data         SRAM address and tristate data bus
//
//   Build option: define SRAM_BYTE_LANES_EN to add the be port. Without it,
//   both byte lanes are enabled for every access.
module sram_mem_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_BYTE_LANES_EN
  input  logic [1:0]        be,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Data
);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              rd_last;

  logic [DATA_W-1:0] wdata_q;
  logic              data_oe;
  logic [1:0]        be_sel;

  logic              ce_nxt, oe_nxt, we_nxt, ub_nxt, lb_nxt;
  logic              ready_nxt, busy_nxt, data_oe_nxt;

  // we_req is consumed by the IDLE branch choice, so it needs no register.
  assign accept  = (state == IDLE) && req;
  assign rd_last = (state == RD) && (cnt == RD_LAST);

  // Lane selection for the strobes of the next cycle. On the accept edge the
  // latched copy is not loaded yet, so the live input is used directly.
`ifdef SRAM_BYTE_LANES_EN
  logic [1:0] be_q;
  assign be_sel = (state == IDLE) ? be : be_q;
`else
  assign be_sel = 2'b11;
`endif

  // State register and wait counter; the counter restarts on every state change.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else                    cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req) state_nxt = we_req ? WR_SETUP : RD;
      RD:       if (cnt == RD_LAST) state_nxt = DONE;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (cnt == WR_LAST) state_nxt = WR_HOLD;
      WR_HOLD:  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode. It is taken from the next state so that the registered
  // strobes line up with the state they describe.
  always_comb begin
    ce_nxt      = 1'b1;
    oe_nxt      = 1'b1;
    we_nxt      = 1'b1;
    ub_nxt      = 1'b1;
    lb_nxt      = 1'b1;
    data_oe_nxt = 1'b0;
    ready_nxt   = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    case (state_nxt)
      RD: begin
        ce_nxt = 1'b0;
        oe_nxt = 1'b0;
        ub_nxt = ~be_sel[1];
        lb_nxt = ~be_sel[0];
      end
      WR_SETUP, WR_HOLD: begin
        ce_nxt      = 1'b0;
        ub_nxt      = ~be_sel[1];
        lb_nxt      = ~be_sel[0];
        data_oe_nxt = 1'b1;
      end
      WR_PULSE: begin
        ce_nxt      = 1'b0;
        we_nxt      = 1'b0;
        ub_nxt      = ~be_sel[1];
        lb_nxt      = ~be_sel[0];
        data_oe_nxt = 1'b1;
      end
      DONE:    ready_nxt = 1'b1;
      default: ;
    endcase
  end

  // Output registers. Every pin is driven from a flop, so the pins are glitch-free.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      CE      <= 1'b1;
      OE      <= 1'b1;
      WE      <= 1'b1;
      UB      <= 1'b1;
      LB      <= 1'b1;
      ready   <= 1'b0;
      busy    <= 1'b0;
      data_oe <= 1'b0;
      ADDR    <= '0;
      rdata   <= '0;
    end else begin
      CE      <= ce_nxt;
      OE      <= oe_nxt;
      WE      <= we_nxt;
      UB      <= ub_nxt;
      LB      <= lb_nxt;
      ready   <= ready_nxt;
      busy    <= busy_nxt;
      data_oe <= data_oe_nxt;
      if (accept)  ADDR  <= addr;
      if (rd_last) rdata <= Data;
    end
  end

  // Write payload. It is only used under data_oe, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (accept) begin
      wdata_q <= wdata;
`ifdef SRAM_BYTE_LANES_EN
      be_q    <= be;
`endif
    end
  end

  // data_oe is asserted only in write states, where OE is held high.
  assign Data = data_oe ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_mem_ctrl.sv
module tb_sram_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req = 1'b0;
  logic        we_req = 1'b0;
  logic [19:0] addr = '0;
  logic [15:0] wdata = '0;
`ifdef SRAM_BYTE_LANES_EN
  logic [1:0]  be = 2'b11;
`endif
  logic [15:0] rdata;
  logic        ready, busy, CE, OE, WE, UB, LB;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  logic [15:0] mem [0:255] = '{default: 16'h0000};
  logic        probe_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sram_mem_ctrl dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we_req(we_req), .addr(addr),
    .wdata(wdata),
`ifdef SRAM_BYTE_LANES_EN
    .be(be),
`endif
    .rdata(rdata), .ready(ready), .busy(busy), .CE(CE), .OE(OE), .WE(WE),
    .UB(UB), .LB(LB), .ADDR(ADDR), .Data(Data)
  );

  always #5 Clk = ~Clk;

  // Asynchronous SRAM model: it drives on CE&OE, and it writes enabled lanes on the rising edge of WE.
  assign Data = (!CE && !OE && WE) ? mem[ADDR[7:0]] : 16'hzzzz;
  // The probe drives a known pattern. It reads back intact only if nothing else drives the bus.
  assign Data = probe_en ? 16'hA5A5 : 16'hzzzz;

  always @(posedge WE) begin
    if (!CE) begin
      if (!UB) mem[ADDR[7:0]][15:8] = Data[15:8];
      if (!LB) mem[ADDR[7:0]][7:0]  = Data[7:0];
    end
  end

  // Strobe vector order: {CE, OE, WE, UB, LB, ready, busy}
  localparam logic [6:0] S_IDLE = 7'b1111100;
  localparam logic [6:0] S_DONE = 7'b1111111;
  localparam logic [6:0] S_RD   = 7'b0010001;
  localparam logic [6:0] S_WSET = 7'b0110001;
  localparam logic [6:0] S_WPUL = 7'b0100001;

  typedef struct packed {
    logic        rq;
    logic        w;
    logic [19:0] a;
    logic [15:0] wd;
    logic [6:0]  st;
    logic        cd;
    logic [15:0] d;
    logic        cz;
    logic        cr;
    logic [15:0] r;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t v(logic rq, logic w, logic [19:0] a, logic [15:0] wd,
                             logic [6:0] st, logic cd, logic [15:0] d,
                             logic cz, logic cr, logic [15:0] r);
    vec_t t;
    t.rq = rq; t.w = w; t.a = a; t.wd = wd; t.st = st;
    t.cd = cd; t.d = d; t.cz = cz; t.cr = cr; t.r = r;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({CE, OE, WE, UB, LB, ready, busy});
  endfunction

  // Single read with a bounded wait for ready.
  task automatic do_read(input string name, input logic [19:0] a, input logic [15:0] exp);
    int lat;
    logic got;
    @(negedge Clk);
    req = 1'b1; we_req = 1'b0; addr = a; wdata = 16'h0F0F;
    @(posedge Clk);
    @(negedge Clk);
    req = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(posedge Clk); #1;
      if (ready) begin got = 1'b1; lat = k; end
    end
    chk({name, "_ready_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({name, "_latency"}, 32'(lat), 32'd2);
      chk({name, "_rdata"}, 32'(rdata), 32'(exp));
    end
    @(posedge Clk); #1;
  endtask

`ifdef SRAM_BYTE_LANES_EN
  task automatic do_write_be(input string name, input logic [19:0] a,
                             input logic [15:0] d, input logic [1:0] b);
    logic got;
    @(negedge Clk);
    req = 1'b1; we_req = 1'b1; addr = a; wdata = d; be = b;
    @(posedge Clk); #1;
    chk({name, "_ub_lb"}, 32'({UB, LB}), 32'(~b));
    @(negedge Clk);
    req = 1'b0; be = 2'b11;
    got = 1'b0;
    for (int k = 2; k <= 12 && !got; k++) begin
      @(posedge Clk); #1;
      if (ready) got = 1'b1;
    end
    chk({name, "_ready_seen"}, 32'(got), 32'd1);
    @(posedge Clk); #1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rdy_cnt, last_rdy, low_run, max_low;

    // Vector k drives the inputs during cycle k. Its expectations are the cycle k+1 outputs.
    vecs[0]  = v(1, 1, 20'h00031, 16'hBEEF, S_WSET, 1, 16'hBEEF, 0, 0, 16'h0);
    vecs[1]  = v(0, 0, 20'h00000, 16'h0000, S_WPUL, 1, 16'hBEEF, 0, 0, 16'h0);
    vecs[2]  = v(0, 0, 20'h00000, 16'h0000, S_WPUL, 1, 16'hBEEF, 0, 0, 16'h0);
    vecs[3]  = v(0, 0, 20'h00000, 16'h0000, S_WSET, 1, 16'hBEEF, 0, 0, 16'h0);
    vecs[4]  = v(0, 0, 20'h00000, 16'h0000, S_DONE, 0, 16'h0,    1, 0, 16'h0);
    vecs[5]  = v(0, 0, 20'h00000, 16'h0000, S_IDLE, 0, 16'h0,    1, 0, 16'h0);
    vecs[6]  = v(1, 0, 20'h00031, 16'h1111, S_RD,   1, 16'hBEEF, 0, 0, 16'h0);
    vecs[7]  = v(1, 1, 20'h00040, 16'h2222, S_RD,   1, 16'hBEEF, 0, 0, 16'h0);
    vecs[8]  = v(1, 1, 20'h00040, 16'h2222, S_DONE, 0, 16'h0,    1, 1, 16'hBEEF);
    vecs[9]  = v(0, 0, 20'h00000, 16'h0000, S_IDLE, 0, 16'h0,    1, 1, 16'hBEEF);
    vecs[10] = v(0, 0, 20'h00000, 16'h0000, S_IDLE, 0, 16'h0,    0, 1, 16'hBEEF);

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    probe_en = 1'b1;
    #1;
    chk("reset_strobes", strobes(), 32'(S_IDLE));
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_addr", 32'(ADDR), 32'h0);
    chk("reset_data_z", 32'(Data), 32'hA5A5);
    probe_en = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;

    // Write 0x31 <= BEEF, then read it back, with changing and ignored requests.
    for (int i = 0; i < 11; i++) begin
      @(negedge Clk);
      req = vecs[i].rq; we_req = vecs[i].w; addr = vecs[i].a; wdata = vecs[i].wd;
      @(posedge Clk); #1;
      probe_en = vecs[i].cz;
      #1;
      chk($sformatf("vec%0d_strobes", i), strobes(), 32'(vecs[i].st));
      if (vecs[i].st[6] == 1'b0)
        chk($sformatf("vec%0d_addr", i), 32'(ADDR), 32'h31);
      if (vecs[i].cd) chk($sformatf("vec%0d_data", i), 32'(Data), 32'(vecs[i].d));
      if (vecs[i].cz) chk($sformatf("vec%0d_data_z", i), 32'(Data), 32'hA5A5);
      if (vecs[i].cr) chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].r));
      probe_en = 1'b0;
    end
    chk("mem_0x31", 32'(mem[8'h31]), 32'hBEEF);

    // Hold req high as a read for 20 edges. Expect back-to-back accepts every 4 cycles.
    @(negedge Clk);
    req = 1'b1; we_req = 1'b0; addr = 20'h00031;
    rdy_cnt = 0; last_rdy = -1; low_run = 0; max_low = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk); #1;
      if (ready) begin
        rdy_cnt++;
        chk($sformatf("held_rdata_%0d", c), 32'(rdata), 32'hBEEF);
        if (last_rdy >= 0) chk($sformatf("held_period_%0d", c), 32'(c - last_rdy), 32'd4);
        last_rdy = c;
      end
      if (!busy) begin
        low_run++;
        if (low_run > max_low) max_low = low_run;
      end else begin
        low_run = 0;
      end
    end
    @(negedge Clk);
    req = 1'b0;
    chk("held_ready_count", 32'(rdy_cnt), 32'd5);
    chk("held_busy_low_max", 32'(max_low), 32'd1);
    repeat (3) @(posedge Clk);

    // Reset pulsed during cycle 2 of a write to 0x40
    @(negedge Clk);
    req = 1'b1; we_req = 1'b1; addr = 20'h00040; wdata = 16'h5555;
    @(posedge Clk);
    @(negedge Clk);
    req = 1'b0;
    @(posedge Clk); #1;
    chk("abort_pre_strobes", strobes(), 32'(S_WPUL));
    #2;
    Reset = 1'b0;
    probe_en = 1'b1;
    #1;
    chk("abort_strobes", strobes(), 32'(S_IDLE));
    chk("abort_rdata", 32'(rdata), 32'h0);
    chk("abort_data_z", 32'(Data), 32'hA5A5);
    @(posedge Clk); #1;
    chk("abort_no_ready", 32'(ready), 32'h0);
    probe_en = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    do_read("after_abort", 20'h00031, 16'hBEEF);

`ifdef SRAM_BYTE_LANES_EN
    do_write_be("be01", 20'h00031, 16'h1234, 2'b01);
    do_read("be01_rd", 20'h00031, 16'hBE34);
    do_write_be("be00", 20'h00031, 16'h0000, 2'b00);
    do_read("be00_rd", 20'h00031, 16'hBE34);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
